// File: rtl/rw_mem_pkg.sv
// rw_mem_pkg: shared state type, window decode helper and legacy map defaults for rw_mem_sync_param
package rw_mem_pkg;
  typedef enum logic {ST_CLEAR, ST_READY} state_e;
  localparam int DEF_BASE = 128;
  localparam int DEF_DEPTH = 96;
  function automatic logic in_window(input longint unsigned addr, input longint unsigned base,
                                     input longint unsigned depth);
    return (addr >= base) && (addr <= base + depth - 1);
  endfunction
endpackage

// File: rtl/rw_mem_clear_seq.sv
// rw_mem_clear_seq: state register and pointer that zero every word after reset or on clr
module rw_mem_clear_seq
  import rw_mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [IW-1:0] clr_addr
);
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic last;
  assign last = ptr_q == IW'(DEPTH - 1);
  // state and pointer registers; reset starts a fresh clear pass
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end
  // walk the pointer across the array; clr restarts it from zero in any state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (clr) begin
      state_d = ST_CLEAR;
      ptr_d   = '0;
    end else if (state_q == ST_CLEAR) begin
      state_d = last ? ST_READY : ST_CLEAR;
      ptr_d   = last ? '0 : ptr_q + 1'b1;
    end
  end
  assign busy     = state_q == ST_CLEAR;
  assign clr_we   = busy;
  assign clr_addr = ptr_q;
endmodule

// File: rtl/rw_mem_sync_param.sv
// rw_mem_sync_param: address-mapped synchronous RW memory with clear sequencer; RW_MEM_PARITY_EN adds per-word parity
module rw_mem_sync_param
  import rw_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int BASE   = DEF_BASE,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              WE,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              hit,
  output logic              busy,
  output logic              parity_err
);
  if ((longint'(BASE) + longint'(DEPTH) - 1 > (longint'(1) << ADDR_W) - 1) || DEPTH < 2) begin : g_bad_cfg
    $error("rw_mem_sync_param: window exceeds address space or DEPTH < 2");
  end
`ifdef RW_MEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] wdata;
  logic [IW-1:0] idx, clr_addr;
  logic clr_we, acc, rd;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic valid_q, valid_d;
  rw_mem_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );
  assign hit = req && in_window(64'(address), 64'(BASE), 64'(DEPTH));
  assign idx = IW'(address - ADDR_W'(BASE));
  // clr takes priority over a same-cycle access; busy blocks everything
  assign acc = hit && !busy && !clr;
  assign rd  = acc && !WE;
`ifdef RW_MEM_PARITY_EN
  assign wdata = {^data_in, data_in};
`else
  assign wdata = data_in;
`endif
  // array write mux: clear sequencer owns the port while busy
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_addr] <= '0;
    else if (acc && WE) mem[idx] <= wdata;
  end
  // read data holds between reads; valid is a one-cycle strobe per read
  always_comb begin
    data_out_d = rd ? mem[idx][DATA_W-1:0] : data_out_q;
    valid_d    = rd;
  end
  // read register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end
  assign data_out   = data_out_q;
  assign data_valid = valid_q;
`ifdef RW_MEM_PARITY_EN
  logic perr_q, perr_d;
  assign perr_d = rd && (^mem[idx]);
  // parity flag registered alongside the read strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perr_q <= 1'b0;
    else perr_q <= perr_d;
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_rw_mem_sync_param.sv
// tb_rw_mem_sync_param: directed bench with read-data scoreboard for rw_mem_sync_param
module tb_rw_mem_sync_param;
  logic clk = 1'b0, reset_n = 1'b0, req = 1'b0, WE = 1'b0, clr = 1'b0;
  logic [7:0] address = '0, data_in = '0;
  logic [7:0] data_out;
  logic data_valid, hit, busy, parity_err;
  typedef struct {logic [7:0] d; logic p;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;
  int n;

  rw_mem_sync_param dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .WE        (WE),
    .address   (address),
    .data_in   (data_in),
    .clr       (clr),
    .data_out  (data_out),
    .data_valid(data_valid),
    .hit       (hit),
    .busy      (busy),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one bus cycle, entered and left at posedge+1
  task automatic acc(input logic w, input logic [7:0] a, input logic [7:0] d, input logic c,
                     input logic exp_hit, input logic push, input logic [7:0] ed, input logic ep);
    req = 1'b1; WE = w; address = a; data_in = d; clr = c;
    #1 chk("hit", hit, exp_hit);
    if (push) sb.push_back('{ed, ep});
    @(posedge clk);
    #1 req = 1'b0; WE = 1'b0; clr = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic exp_hit);
    acc(1'b1, a, d, 1'b0, exp_hit, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] ed, input logic ep);
    acc(1'b0, a, 8'h00, 1'b0, 1'b1, 1'b1, ed, ep);
  endtask

  // counts cycles with busy high, bounded
  task automatic wait_ready(output int cnt);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n && data_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_valid", data_valid, 1'b0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", data_out, e.d);
        chk("perr", parity_err, e.p);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_busy", busy, 1'b1);
    reset_n = 1'b1;
    wait_ready(n);
    chk("reset_clear_cycles", n, 96);
    rd(8'd128, 8'h00, 1'b0);
    chk("valid_pulse_hi", data_valid, 1'b1);
    @(posedge clk);
    #1 chk("valid_pulse_lo", data_valid, 1'b0);
    wr(8'd130, 8'hA5, 1'b1);
    wr(8'd223, 8'h3C, 1'b1);
    rd(8'd223, 8'h3C, 1'b0);
    chk("b2b_first", data_valid, 1'b1);
    rd(8'd130, 8'hA5, 1'b0);
    chk("b2b_second", data_valid, 1'b1);
    chk("b2b_data", data_out, 8'hA5);
    wr(8'd127, 8'h77, 1'b0);
    wr(8'd224, 8'h77, 1'b0);
    wr(8'd0, 8'h99, 1'b0);
    rd(8'd128, 8'h00, 1'b0);
    rd(8'd223, 8'h3C, 1'b0);
    wr(8'd150, 8'h22, 1'b1);
    rd(8'd150, 8'h22, 1'b0);
    acc(1'b1, 8'd150, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("busy_after_clr", busy, 1'b1);
    wr(8'd140, 8'hFF, 1'b1);
    acc(1'b0, 8'd140, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    wait_ready(n);
    // two of the 96 busy cycles were spent on the ignored accesses above
    chk("clr_cycles", n, 94);
    rd(8'd150, 8'h00, 1'b0);
    rd(8'd140, 8'h00, 1'b0);
    rd(8'd130, 8'h00, 1'b0);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    repeat (10) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    wait_ready(n);
    chk("clr_restart_cycles", n, 96);
`ifdef RW_MEM_PARITY_EN
    wr(8'd133, 8'h5A, 1'b1);
    wr(8'd134, 8'h5A, 1'b1);
    dut.mem[5] = dut.mem[5] ^ 9'h100;
    rd(8'd133, 8'h5A, 1'b1);
    rd(8'd134, 8'h5A, 1'b0);
    @(posedge clk);
    #1;
`endif
    wr(8'd130, 8'hC3, 1'b1);
    acc(1'b0, 8'd130, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("pre_rst_valid", data_valid, 1'b1);
    chk("pre_rst_data", data_out, 8'hC3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", data_valid, 1'b0);
    chk("async_rst_data", data_out, 8'h00);
    chk("async_rst_busy", busy, 1'b1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_ready(n);
    chk("rst_restart_cycles", n, 96);
    rd(8'd130, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rw_mem_sync_param.md
Name: rw_mem_sync_param

Overview:
Parametrised, address-mapped, synchronous single-port read/write memory for the computer's data bus; successor to the fixed 96x8 RW window.
- Decodes its own window [BASE, BASE+DEPTH-1] out of the full address space.
- Adds a registered read-valid strobe, a hardware clear sequencer (runs after reset and on command) with a busy flag, and optional per-word parity checking.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, bus address width.
- BASE, 128, first address mapped to this memory.
- DEPTH, 96, number of words. Elaboration error if BASE+DEPTH-1 > 2^ADDR_W-1 or DEPTH < 2.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous reset, active-low.
- req  in  1  bus access request, sampled at posedge clk.
- WE  in  1  1 = write, 0 = read; qualified by req.
- address  in  ADDR_W  bus address.
- data_in  in  DATA_W  write data.
- clr  in  1  single-cycle pulse; restarts the clear sequence.
- data_out  out  DATA_W  registered read data.
- data_valid  out  1  high for exactly one cycle when data_out carries new read data.
- hit  out  1  combinational: req && address inside window.
- busy  out  1  high while clearing; accesses ignored.
- parity_err  out  1  parity mismatch on the read presented this cycle.

Behaviour:
- Reset (reset_n=0, async): data_out=0, data_valid=0, parity_err=0, busy=1, state=CLEAR, clear pointer=0. Memory contents are not reset directly; the clear sequence zeroes them.
- Index: idx = address - BASE, width $clog2(DEPTH). hit uses unsigned compares BASE <= address <= BASE+DEPTH-1.
- State CLEAR:
  - Each cycle writes 0 to mem[ptr], then ptr++.
  - After the write of ptr=DEPTH-1, next state is READY and busy drops on that edge. Clearing takes exactly DEPTH cycles after reset release.
  - req is ignored in CLEAR: not queued, no write, data_valid=0.
- State READY:
  - req && hit && WE: mem[idx] <= data_in at the edge. data_out holds its value; data_valid=0.
  - req && hit && !WE: data_out <= mem[idx] at the edge and data_valid=1 for that one following cycle. Read latency is 1 clock.
  - req && !hit, or !req: no memory action; data_out holds; data_valid=0.
  - Back-to-back reads: data_valid stays high on consecutive cycles, with new data each cycle.
  - A write at cycle N followed by a read of the same address at cycle N+1 returns the new data. No bypass is needed because this is sequential.
  - clr=1: next state is CLEAR, ptr=0, busy=1. If clr and req arrive together, clr wins and req is dropped.
- clr while already in CLEAR: ptr restarts at 0.
- Reset asserted mid-clear or mid-access: everything returns to reset values immediately; the clear sequence restarts on release.
- hit is asserted even while busy, so the bus decoder can still route the access; the master must check busy.

Optional Feature:
Macro RW_MEM_PARITY_EN.
- Defined:
  - Each word stores DATA_W+1 bits; the extra bit holds the even parity of data_in, written on every write.
  - Clear writes all zeros, which is valid parity.
  - On a read, parity_err is registered alongside data_valid: it is 1 for that one cycle if the stored parity is wrong, and 0 otherwise.
- Undefined: storage is DATA_W bits and parity_err is tied to 0.

Decomposition:
- Package rw_mem_pkg holds:
  - The state enum {ST_CLEAR, ST_READY}.
  - Function in_window(addr, base, depth).
  - Localparam defaults matching the legacy map (BASE 128, DEPTH 96).
- One sub-module, rw_mem_clear_seq, holds the state register, the clear pointer, busy, and the clear write-enable/address. It feeds the top level's array write mux.
- The array and read register stay in the top level.

Test Plan:
- Reset clear: release reset_n, hold req=0 → busy=1 for exactly 96 cycles, then 0. A read of address 128 then returns data_out=0x00 with data_valid=1 one cycle later.
- Write/read: write 0xA5 to 130 and 0x3C to 223, then read 223 and 130 back-to-back → data_valid high 2 consecutive cycles with 0x3C then 0xA5.
- Window boundaries: write to 127 and to 224 → hit=0 and no memory change. Read 128 and 223 → hit=1 and the data written earlier is returned.
- Access during busy: issue req write 0xFF to 140 during clear → ignored; after busy drops, read 140 → 0x00.
- clr priority: pulse clr in the same cycle as a write of 0x11 to 150 → busy=1 for 96 cycles; read 150 afterwards → 0x00.
- RW_MEM_PARITY_EN: bench deposits a flipped parity bit at index 5. A read of 133 → parity_err=1 together with data_valid=1. A read of 134 → parity_err=0.
